// File: rtl/multicycle_datapath.sv
// Multicycle 32-bit core: IMEM/DMEM 256x32, 32x32 register file, FETCH/DECODE/EXEC/MEM/WB sequencing.
// IMEM is loaded through the write port; execution starts at PC 0 when start is raised.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start, PC held
// FETCH   | IR <= IMEM[PC[7:0]]
// DECODE  | operand read into A/B; NOP-class ops retire here
// EXEC    | ALUOut <= result; BEQ resolves and retires here
// MEM     | LWI reads DMEM into MDR; SWI writes DMEM and retires
// WB      | register write, retire
module multicycle_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        I_MEM_Write_Enable,
    input  logic [31:0] I_MEM_Data_In,
    input  logic [15:0] I_MEM_Write_Addr,
    output logic [31:0] ALUOut,
    output logic [31:0] PC_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [5:0] OP_MOV  = 6'b010000;
    localparam logic [5:0] OP_ADD  = 6'b010010;
    localparam logic [5:0] OP_SUB  = 6'b010011;
    localparam logic [5:0] OP_OR   = 6'b010100;
    localparam logic [5:0] OP_AND  = 6'b010101;
    localparam logic [5:0] OP_ADDI = 6'b110010;
    localparam logic [5:0] OP_SUBI = 6'b110011;
    localparam logic [5:0] OP_ORI  = 6'b110100;
    localparam logic [5:0] OP_ANDI = 6'b110101;
    localparam logic [5:0] OP_LI   = 6'b111001;
    localparam logic [5:0] OP_LWI  = 6'b111011;
    localparam logic [5:0] OP_SWI  = 6'b111100;
    localparam logic [5:0] OP_BEQ  = 6'b100000;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    logic [31:0] rf   [32];

    logic [2:0]  state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mdr;

    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] sext;
    logic [31:0] zext;
    logic        is_lwi;
    logic        is_swi;
    logic        is_beq;
    logic        is_exec_op;
    logic [31:0] alu_res;
    logic [2:0]  retire_state;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        dmem_we;
    logic        unused_addr_bits;

    assign op     = ir[31:26];
    assign rd     = ir[25:21];
    assign rs     = ir[20:16];
    assign rt     = ir[15:11];
    assign sext   = {{16{ir[15]}}, ir[15:0]};
    assign zext   = {16'h0000, ir[15:0]};
    assign is_lwi = (op == OP_LWI);
    assign is_swi = (op == OP_SWI);
    assign is_beq = (op == OP_BEQ);

    assign PC_out           = pc;
    assign retire_state     = start ? S_FETCH : S_IDLE;
    assign unused_addr_bits = ^I_MEM_Write_Addr[15:8];

    // Anything not recognised here retires from DECODE like a NOP.
    always_comb begin
        is_exec_op = 1'b0;
        case (op)
            OP_MOV, OP_ADD, OP_SUB, OP_OR, OP_AND,
            OP_ADDI, OP_SUBI, OP_ORI, OP_ANDI,
            OP_LI, OP_LWI, OP_SWI, OP_BEQ: is_exec_op = 1'b1;
            default:                       is_exec_op = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = ALUOut;
        case (op)
            OP_MOV:          alu_res = a;
            OP_ADD:          alu_res = a + b;
            OP_SUB:          alu_res = a - b;
            OP_OR:           alu_res = a | b;
            OP_AND:          alu_res = a & b;
            OP_ADDI:         alu_res = a + sext;
            OP_SUBI:         alu_res = a - sext;
            OP_ORI:          alu_res = a | zext;
            OP_ANDI:         alu_res = a & zext;
            OP_LI:           alu_res = sext;
            OP_LWI, OP_SWI:  alu_res = zext;
            OP_BEQ:          alu_res = b - a;
            default:         alu_res = ALUOut;
        endcase
    end

    always_ff @(posedge clk) begin
        if (I_MEM_Write_Enable) begin
            imem[I_MEM_Write_Addr[7:0]] <= I_MEM_Data_In;
        end
    end

    assign dmem_we = (state == S_MEM) && is_swi;

    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem[ALUOut[7:0]] <= b;
        end
    end

    // WB is only entered by register-writing ops, so the r0 guard is the only filter.
    assign rf_we    = (state == S_WB) && (rd != 5'd0);
    assign rf_waddr = rd;
    assign rf_wdata = is_lwi ? mdr : ALUOut;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            mdr    <= '0;
            ALUOut <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= imem[pc[7:0]];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    a <= rf[rs];
                    b <= (is_swi || is_beq) ? rf[rd] : rf[rt];
                    if (is_exec_op) begin
                        state <= S_EXEC;
                    end else begin
                        pc    <= pc + 32'd1;
                        state <= retire_state;
                    end
                end
                S_EXEC: begin
                    ALUOut <= alu_res;
                    if (is_beq) begin
                        pc    <= (a == b) ? pc + sext : pc + 32'd1;
                        state <= retire_state;
                    end else if (is_lwi || is_swi) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (is_lwi) begin
                        mdr   <= dmem[ALUOut[7:0]];
                        state <= S_WB;
                    end else begin
                        pc    <= pc + 32'd1;
                        state <= retire_state;
                    end
                end
                S_WB: begin
                    pc    <= pc + 32'd1;
                    state <= retire_state;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: expected register writes and per-instruction
// retire records (next PC, ALUOut, latency) are queued by stimulus and popped by a monitor.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_we;
    logic [31:0] imem_din;
    logic [15:0] imem_addr;
    logic [31:0] alu_out;
    logic [31:0] pc_out;

    multicycle_datapath dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .I_MEM_Write_Enable (imem_we),
        .I_MEM_Data_In      (imem_din),
        .I_MEM_Write_Addr   (imem_addr),
        .ALUOut             (alu_out),
        .PC_out             (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        int          dur;
    } ret_t;

    wr_t  wr_q[$];
    ret_t ret_q[$];
    wr_t  mon_w;
    ret_t mon_r;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    int cyc = 0;
    logic [31:0] last_pc = '0;

    logic [31:0] prog     [20];
    int          exp_next [20];
    int          exp_dur  [20];
    logic [31:0] exp_alu  [20];

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] er(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic build_tables();
        prog[0]  = ei(6'b111001, 1, 0, 16'd5);       // LI   r1, 5
        prog[1]  = ei(6'b110010, 2, 1, 16'd5);       // ADDI r2, r1, 5
        prog[2]  = ei(6'b110010, 3, 0, 16'hFFF8);    // ADDI r3, r0, -8
        prog[3]  = ei(6'b110011, 4, 0, 16'd1);       // SUBI r4, r0, 1
        prog[4]  = ei(6'b110100, 5, 0, 16'hAAAA);    // ORI  r5, r0, 0xAAAA
        prog[5]  = ei(6'b110101, 6, 5, 16'h5555);    // ANDI r6, r5, 0x5555
        prog[6]  = er(6'b010000, 7, 1, 0);           // MOV  r7, r1
        prog[7]  = er(6'b010000, 8, 2, 0);           // MOV  r8, r2
        prog[8]  = er(6'b010010, 10, 7, 8);          // ADD
        prog[9]  = er(6'b010011, 11, 7, 8);          // SUB
        prog[10] = er(6'b010100, 12, 7, 9);          // OR
        prog[11] = er(6'b010101, 13, 8, 4);          // AND
        prog[12] = ei(6'b110010, 0, 1, 16'd7);       // ADDI r0 (discarded)
        prog[13] = ei(6'b111111, 5, 1, 16'h1234);    // undefined opcode
        prog[14] = ei(6'b100000, 12, 13, 16'd5);     // BEQ not taken
        prog[15] = ei(6'b100000, 8, 13, 16'd2);      // BEQ taken -> 17
        prog[16] = er(6'b010000, 13, 1, 0);          // skipped MOV
        prog[17] = ei(6'b111100, 13, 0, 16'h0080);   // SWI
        prog[18] = ei(6'b111011, 14, 0, 16'h0080);   // LWI
        prog[19] = ei(6'b111001, 15, 0, 16'd1);      // LI   r15, 1
        for (int i = 0; i < 20; i++) begin
            exp_next[i] = i + 1;
            exp_dur[i]  = 4;
        end
        exp_next[15] = 17;
        exp_dur[13] = 2;
        exp_dur[14] = 3;
        exp_dur[15] = 3;
        exp_dur[18] = 5;
        exp_alu[0]  = 32'h5;        exp_alu[1]  = 32'hA;
        exp_alu[2]  = 32'hFFFFFFF8; exp_alu[3]  = 32'hFFFFFFFF;
        exp_alu[4]  = 32'h0000AAAA; exp_alu[5]  = 32'h0;
        exp_alu[6]  = 32'h5;        exp_alu[7]  = 32'hA;
        exp_alu[8]  = 32'hF;        exp_alu[9]  = 32'hFFFFFFFB;
        exp_alu[10] = 32'h5;        exp_alu[11] = 32'hA;
        exp_alu[12] = 32'hC;        exp_alu[13] = 32'hC;
        exp_alu[14] = 32'hFFFFFFFB; exp_alu[15] = 32'h0;
        exp_alu[16] = 32'h0;        exp_alu[17] = 32'h80;
        exp_alu[18] = 32'h80;       exp_alu[19] = 32'h1;
    endtask

    // Queue retire records and register writes for one pass, stopping once PC reaches base+stop.
    task automatic push_pass(input logic [31:0] base, input int stop, input bit skip_first);
        int p;
        bit first;
        p = 0;
        first = skip_first;
        while (p < 20 && p < stop) begin
            ret_q.push_back('{pc: base + 32'(exp_next[p]), alu: exp_alu[p],
                              dur: first ? 0 : exp_dur[p]});
            first = 1'b0;
            p = exp_next[p];
        end
        for (int q = 20; q < stop && q < 256; q++) begin
            ret_q.push_back('{pc: base + 32'(q + 1), alu: 32'h1, dur: 2});
        end
        if (stop > 0)  wr_q.push_back('{rd: 5'd1,  data: 32'h5});
        if (stop > 1)  wr_q.push_back('{rd: 5'd2,  data: 32'hA});
        if (stop > 2)  wr_q.push_back('{rd: 5'd3,  data: 32'hFFFFFFF8});
        if (stop > 3)  wr_q.push_back('{rd: 5'd4,  data: 32'hFFFFFFFF});
        if (stop > 4)  wr_q.push_back('{rd: 5'd5,  data: 32'h0000AAAA});
        if (stop > 5)  wr_q.push_back('{rd: 5'd6,  data: 32'h0});
        if (stop > 6)  wr_q.push_back('{rd: 5'd7,  data: 32'h5});
        if (stop > 7)  wr_q.push_back('{rd: 5'd8,  data: 32'hA});
        if (stop > 8)  wr_q.push_back('{rd: 5'd10, data: 32'hF});
        if (stop > 9)  wr_q.push_back('{rd: 5'd11, data: 32'hFFFFFFFB});
        if (stop > 10) wr_q.push_back('{rd: 5'd12, data: 32'h5});
        if (stop > 11) wr_q.push_back('{rd: 5'd13, data: 32'hA});
        if (stop > 18) wr_q.push_back('{rd: 5'd14, data: 32'hA});
        if (stop > 19) wr_q.push_back('{rd: 5'd15, data: 32'h1});
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((ret_q.size() != 0 || wr_q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (ret_q.size() != 0 || wr_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: timeout with %0d retires and %0d writes outstanding, expected 0",
                     name, ret_q.size(), wr_q.size());
        end
    endtask

    // Monitor: register-write port and instruction retire (PC change) events.
    always @(negedge clk) begin
        if (!mon_en) begin
            cyc = 0;
            last_pc = pc_out;
        end else begin
            cyc++;
            if (dut.rf_we) begin
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rf_write: got unexpected r%0d=%h, expected no write",
                             dut.rf_waddr, dut.rf_wdata);
                end else begin
                    mon_w = wr_q.pop_front();
                    check("rf_waddr", 32'(dut.rf_waddr), 32'(mon_w.rd));
                    check($sformatf("rf_wdata r%0d", mon_w.rd), dut.rf_wdata, mon_w.data);
                end
            end
            if (pc_out != last_pc) begin
                if (ret_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pc_change: got unexpected PC %h after %h, expected no change",
                             pc_out, last_pc);
                end else begin
                    mon_r = ret_q.pop_front();
                    check($sformatf("next_pc after %h", last_pc), pc_out, mon_r.pc);
                    check($sformatf("aluout after %h", last_pc), alu_out, mon_r.alu);
                    if (mon_r.dur != 0) begin
                        check($sformatf("latency of %h", last_pc), 32'(cyc), 32'(mon_r.dur));
                    end
                end
                cyc = 0;
                last_pc = pc_out;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        build_tables();
        rst = 1'b1;
        start = 1'b0;
        imem_we = 1'b0;
        imem_din = '0;
        imem_addr = '0;
        #12;
        check("reset pc", pc_out, 32'h0);
        check("reset aluout", alu_out, 32'h0);
        check("reset state", 32'(dut.state), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Load while idle: monitor flags any PC change or register write.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            imem_we = 1'b1;
            imem_addr = 16'(i);
            imem_din = (i < 20) ? prog[i] : 32'h0;
        end
        @(negedge clk);
        imem_we = 1'b0;
        repeat (5) @(negedge clk);
        check("idle pc", pc_out, 32'h0);
        check("idle aluout", alu_out, 32'h0);
        check("idle r1", dut.rf[1], 32'h0);

        // Full pass, NOP run to 255, wrap, second pass up to the ADD at 264.
        push_pass(32'h0, 256, 1'b1);
        push_pass(32'h100, 8, 1'b0);
        start = 1'b1;
        wait_drain(4000, "run_drain");
        check("r0 after write", dut.rf[0], 32'h0);
        mon_en = 1'b0;

        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (dut.state != 3'd3 && n < 40);
        check("reached exec", 32'(dut.state), 32'h3);
        check("exec pc", pc_out, 32'h108);
        #1;
        rst = 1'b1;
        start = 1'b0;
        #1;
        check("async rst pc", pc_out, 32'h0);
        check("async rst aluout", alu_out, 32'h0);
        check("async rst state", 32'(dut.state), 32'h0);
        check("async rst r1", dut.rf[1], 32'h0);
        check("async rst r10", dut.rf[10], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post rst idle pc", pc_out, 32'h0);

        // Restart from retained IMEM: same results as the first pass.
        mon_en = 1'b1;
        push_pass(32'h0, 20, 1'b1);
        @(negedge clk);
        start = 1'b1;
        wait_drain(400, "rerun_drain");
        mon_en = 1'b0;
        check("rerun r14", dut.rf[14], 32'hA);
        check("rerun r13", dut.rf[13], 32'hA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
